inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the CPU core. It generates sequential fetch addresses and issues pipelined word reads to a variable-latency instruction memory. Returned words are buffered in a small in-order prefetch FIFO and delivered to the core with a valid/ready handshake, each tagged with its PC. A redirect input (branch/jump) flushes buffered and in-flight fetches and restarts fetch at a new address.

Parameters:
RESET_PC, 32'h00400000, first fetch address after reset
DEPTH, 4, prefetch FIFO entries; also the maximum of buffered plus in-flight fetches (power of 2, >=2)

Ports:
clk_cpu  input  1  CPU clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
redirect  input  1  one-cycle pulse: flush and restart fetch
redirect_pc  input  32  new fetch address; bits [1:0] ignored (forced 0)
mem_req  output  1  read request valid
mem_adrs  output  32  word-aligned read address
mem_gnt  input  1  request accepted this cycle (meaningful only when mem_req=1)
mem_rvalid  input  1  read data valid; responses return in request order
mem_rdata  input  32  read data
inst  output  32  instruction at FIFO head; 32'h0 (NOP) when inst_valid=0
inst_pc  output  32  PC of inst; 32'h0 when inst_valid=0
inst_valid  output  1  FIFO non-empty
inst_ready  input  1  core accepts inst this cycle

Behaviour:
- Reset (async, immediate): fetch_pc=RESET_PC, resp_pc=RESET_PC, FIFO empty, outstanding=0, discard=0. Outputs: mem_req=0, mem_adrs=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
- Issue: mem_req = (count + outstanding < DEPTH) && !redirect. mem_adrs = fetch_pc. On mem_req && mem_gnt: fetch_pc += 4 (mod 2^32, 0xFFFFFFFC wraps to 0x0) and outstanding += 1. mem_req may stay high across back-to-back grants.
- Response: on mem_rvalid, outstanding -= 1. If discard > 0, discard -= 1 and the word is dropped. Otherwise {resp_pc, mem_rdata} is pushed and resp_pc += 4. Grant and rvalid in the same cycle leave outstanding unchanged.
- mem_rvalid while outstanding=0 is a protocol error: ignore it, change no state, and flag it with a simulation assertion. Push into a full FIFO cannot occur because of the credit rule; flag it with an assertion.
- Output: first-word-fall-through from FIFO head. Pop on inst_valid && inst_ready. Push and pop may occur in the same cycle. There is no bypass: a word pushed at edge T is visible from T onward, so the minimum latency is grant at cycle G, rvalid at G+1, inst_valid at G+2.
- Redirect at cycle N, which has priority over all other events:
  - FIFO flushed at the N edge; any pop in cycle N is irrelevant to FIFO state.
  - mem_req=0 in cycle N.
  - fetch_pc and resp_pc set to {redirect_pc[31:2],2'b00}.
  - discard set to outstanding minus (mem_rvalid in cycle N ? 1 : 0). A response arriving in cycle N is dropped.
  - Cycle N+1: mem_req may assert with mem_adrs = new PC.
- Back-to-back redirects: each recomputes discard from the current outstanding; the last redirect wins.
- Reset mid-operation: all state is cleared asynchronously. The memory side is also reset; responses after reset with outstanding=0 fall under the protocol-error rule above.

Test Plan:
1. Reset release; memory with mem_gnt=1 and rvalid 1 cycle later, rdata=~adrs; inst_ready=1 -> mem_adrs 0x00400000, 0x00400004, 0x00400008 on consecutive cycles. First inst_valid arrives 2 cycles after the first grant with inst_pc=0x00400000 and inst=0xFFBFFFFF; one instruction per cycle thereafter.
2. Backpressure: inst_ready=0 -> after 4 grants mem_req=0 and the FIFO holds PCs 0x00400000..0x0040000C. Raise inst_ready -> those 4 are delivered in order, and mem_req reasserts at 0x00400010 the cycle after the first pop.
3. Redirect with 2 outstanding (memory latency 3); redirect_pc=0x00400100 -> both stale responses are dropped (discard 2 -> 0). mem_adrs=0x00400100 the cycle after redirect; the next inst_pc delivered is 0x00400100.
4. Redirect in the same cycle as mem_rvalid with 3 outstanding -> that word is dropped, discard=2, and no stale inst is ever delivered.
5. redirect_pc=0xFFFFFFFF -> fetch addresses 0xFFFFFFFC then 0x00000000; inst_pc values match.
6. Reset asserted mid-stream with FIFO count 3 and outstanding 1 -> inst_valid, mem_req, inst and inst_pc go to 0 without waiting for a clock edge. After release, fetch restarts at 0x00400000; a spurious mem_rvalid is ignored.

Source files
------------

// File: rtl/inst_fetch_unit_if.sv
// Signal bundle between the fetch unit, the instruction memory and the core.
// master = fetch unit side, slave = memory/core side.
interface inst_fetch_unit_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_adrs;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;

  // Handshakes: a memory request transfers on mem_req && mem_gnt, an instruction
  // transfers on inst_valid && inst_ready; mem_rvalid is a one-cycle response
  // strobe, returned in request order, with no back-pressure.
  modport master (
    input  redirect, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, inst_ready,
    output mem_req, mem_adrs, inst, inst_pc, inst_valid
  );

  modport slave (
    output redirect, redirect_pc, mem_gnt, mem_rvalid, mem_rdata, inst_ready,
    input  mem_req, mem_adrs, inst, inst_pc, inst_valid
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Sequential instruction fetch with a credit-limited prefetch FIFO; a redirect
// flushes the FIFO and drops any responses still in flight.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00400000,
  parameter int          DEPTH    = 4
) (
  input  logic              clk_cpu,
  input  logic              reset,
  inst_fetch_unit_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_fifo_pc   [DEPTH];
  logic [31:0]   r_fifo_data [DEPTH];

  logic [CW:0]   w_inflight;
  logic          w_req;
  logic          w_grant;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  logic [31:0]   w_new_pc;
  logic [CW-1:0] w_grant_ext;
  logic [CW-1:0] w_rsp_ext;
  logic [CW-1:0] w_push_ext;
  logic [CW-1:0] w_pop_ext;
  logic [1:0]    w_unused_pc_lsbs;

  // Buffered words plus in-flight requests never exceed DEPTH, so every
  // response is guaranteed a FIFO slot.
  assign w_inflight  = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_req       = (w_inflight < (CW+1)'(DEPTH)) && !bus.redirect && !reset;
  assign w_grant     = w_req && bus.mem_gnt;
  assign w_rsp       = bus.mem_rvalid && (r_outstanding != '0);
  assign w_valid     = (r_count != '0);
  assign w_push      = w_rsp && (r_discard == '0) && !bus.redirect;
  assign w_pop       = w_valid && bus.inst_ready && !bus.redirect;
  assign w_new_pc    = {bus.redirect_pc[31:2], 2'b00};
  assign w_grant_ext = CW'(w_grant);
  assign w_rsp_ext   = CW'(w_rsp);
  assign w_push_ext  = CW'(w_push);
  assign w_pop_ext   = CW'(w_pop);
  assign w_unused_pc_lsbs = bus.redirect_pc[1:0];

  assign bus.mem_req    = w_req;
  assign bus.mem_adrs   = r_fetch_pc;
  assign bus.inst_valid = w_valid;
  assign bus.inst       = w_valid ? r_fifo_data[r_rd_ptr] : 32'h0;
  assign bus.inst_pc    = w_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0;

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else if (bus.redirect) begin
      // Everything still owed by memory is stale, minus a response landing now.
      r_fetch_pc    <= w_new_pc;
      r_resp_pc     <= w_new_pc;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_outstanding <= r_outstanding - w_rsp_ext;
      r_discard     <= r_outstanding - w_rsp_ext;
    end else begin
      if (w_grant) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      r_outstanding <= r_outstanding + w_grant_ext - w_rsp_ext;
      if (w_rsp) begin
        if (r_discard != '0) begin
          r_discard <= r_discard - 1'b1;
        end else begin
          r_resp_pc <= r_resp_pc + 32'd4;
        end
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + w_push_ext - w_pop_ext;
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_resp_pc;
      r_fifo_data[r_wr_ptr] <= bus.mem_rdata;
    end
  end

  a_no_spurious_rvalid: assert property (
    @(posedge clk_cpu) disable iff (reset) !(bus.mem_rvalid && (r_outstanding == '0))
  );

  a_no_push_when_full: assert property (
    @(posedge clk_cpu) disable iff (reset) !(w_push && (r_count == CW'(DEPTH)))
  );

endmodule
